// File: rtl/quiz_pkg.sv
// Shared types and helpers for the quiz countdown controller.
package quiz_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RUN     = 3'd1,
      LOCK    = 3'd2,
      TIMEOUT = 3'd3,
      FOUL    = 3'd4
   } quiz_state_t;

   localparam int DEF_MAX_COUNT = 999;

   // Lowest index wins when several contestants buzz in the same cycle.
   function automatic logic [1:0] lowest_set(input logic [3:0] v);
      if (v[0])      return 2'd0;
      else if (v[1]) return 2'd1;
      else if (v[2]) return 2'd2;
      else           return 2'd3;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector, one pulse per press.
module sync_edge #(
   parameter int W = 1
) (
   input  logic         clk_50M,
   input  logic         rst_n,
   input  logic [W-1:0] din,
   output logic [W-1:0] pulse
);

   logic [W-1:0] meta;
   logic [W-1:0] sync;
   logic [W-1:0] prev;

   // NOTE: non-blocking assignments make the three stages shift one per edge;
   // blocking ones would collapse them into a single flop.
   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         meta <= '0;
         sync <= '0;
         prev <= '0;
      end else begin
         meta <= din;
         sync <= meta;
         prev <= sync;
      end
   end

   assign pulse = sync & ~prev;

endmodule

// File: rtl/quiz_countdown_ctrl.sv
// Quiz-buzzer countdown FSM: tick divider, count register and buzzer arbitration.
module quiz_countdown_ctrl
   import quiz_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 50_000_000,
   parameter int unsigned MAX_COUNT = DEF_MAX_COUNT
) (
   input  logic       clk_50M,
   input  logic       rst_n,
   input  logic       start_btn,
   input  logic       clear_btn,
   input  logic [3:0] buzz,
   input  logic [9:0] preset,
   output logic [9:0] DataOut,
   output logic       ErrorFlag,
   output logic [1:0] winner,
   output logic       winner_valid,
   output logic       timeout
);

   localparam int unsigned      CNT_W     = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [9:0]       MAX_V     = 10'(MAX_COUNT);

   logic             start_p;
   logic             clear_p;
   logic [3:0]       buzz_p;
   logic [9:0]       eff_preset;
   logic [CNT_W-1:0] tick_cnt;
   logic             tick;
   quiz_state_t      state;

   sync_edge #(.W(1)) u_start (.clk_50M(clk_50M), .rst_n(rst_n), .din(start_btn), .pulse(start_p));
   sync_edge #(.W(1)) u_clear (.clk_50M(clk_50M), .rst_n(rst_n), .din(clear_btn), .pulse(clear_p));
   sync_edge #(.W(4)) u_buzz  (.clk_50M(clk_50M), .rst_n(rst_n), .din(buzz),      .pulse(buzz_p));

   assign eff_preset = (preset > MAX_V) ? MAX_V : preset;
   assign tick       = (tick_cnt == TICK_LAST);

   // NOTE: every output is a flop reset on the same edge as the state, so the
   // scan driver never sees a combinational glitch or a stale value after reset.
   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         state        <= IDLE;
         DataOut      <= '0;
         ErrorFlag    <= 1'b0;
         winner       <= 2'd0;
         winner_valid <= 1'b0;
         timeout      <= 1'b0;
         tick_cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               DataOut  <= eff_preset;
               tick_cnt <= '0;
               if (!clear_p) begin
                  if (|buzz_p) begin
                     state        <= FOUL;
                     ErrorFlag    <= 1'b1;
                     winner       <= lowest_set(buzz_p);
                     winner_valid <= 1'b1;
                  end else if (start_p) begin
                     state <= RUN;
                  end
               end
            end

            RUN: begin
               if (clear_p) begin
                  state    <= IDLE;
                  DataOut  <= eff_preset;
                  tick_cnt <= '0;
               end else if (|buzz_p) begin
                  // Freeze the count even if a tick lands on this edge.
                  state        <= LOCK;
                  winner       <= lowest_set(buzz_p);
                  winner_valid <= 1'b1;
                  tick_cnt     <= '0;
               end else if (DataOut == 10'd0) begin
                  state    <= TIMEOUT;
                  timeout  <= 1'b1;
                  tick_cnt <= '0;
               end else if (tick) begin
                  tick_cnt <= '0;
                  if (DataOut > 10'd1) begin
                     DataOut <= DataOut - 10'd1;
                  end else begin
                     DataOut <= 10'd0;
                     state   <= TIMEOUT;
                     timeout <= 1'b1;
                  end
               end else begin
                  tick_cnt <= tick_cnt + CNT_W'(1);
               end
            end

            LOCK, TIMEOUT, FOUL: begin
               tick_cnt <= '0;
               if (clear_p) begin
                  state        <= IDLE;
                  DataOut      <= eff_preset;
                  ErrorFlag    <= 1'b0;
                  winner       <= 2'd0;
                  winner_valid <= 1'b0;
                  timeout      <= 1'b0;
               end
            end

            default: begin
               state    <= IDLE;
               tick_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_quiz_countdown_ctrl.sv
// Bench for quiz_countdown_ctrl: directed scenarios plus random buttons against a reference model.
module tb_quiz_countdown_ctrl;

   localparam int TD = 4;

   logic       clk_50M = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_btn = 1'b0;
   logic       clear_btn = 1'b0;
   logic [3:0] buzz = 4'd0;
   logic [9:0] preset = 10'd0;
   logic [9:0] DataOut;
   logic       ErrorFlag;
   logic [1:0] winner;
   logic       winner_valid;
   logic       timeout;

   int checks = 0;
   int failures = 0;

   quiz_countdown_ctrl #(.TICK_DIV(TD), .MAX_COUNT(999)) dut (
      .clk_50M(clk_50M), .rst_n(rst_n), .start_btn(start_btn), .clear_btn(clear_btn),
      .buzz(buzz), .preset(preset), .DataOut(DataOut), .ErrorFlag(ErrorFlag),
      .winner(winner), .winner_valid(winner_valid), .timeout(timeout)
   );

   always #10 clk_50M = ~clk_50M;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pin history as a delay line, modes named by their meaning.
   typedef enum {M_IDLE, M_RUN, M_LOCK, M_TIMEOUT, M_FOUL} mode_t;
   mode_t m_mode;
   int    m_data, m_err, m_win, m_wv, m_to, run_cyc;
   bit    m_valid = 0;
   logic  hs [3];
   logic  hc [3];
   logic [3:0] hb [3];

   always @(posedge clk_50M) begin
      logic sp, cp;
      logic [3:0] bp;
      int effp, low;
      if (!rst_n) begin
         m_mode = M_IDLE; m_data = 0; m_err = 0; m_win = 0; m_wv = 0; m_to = 0; run_cyc = 0;
         for (int i = 0; i < 3; i++) begin hs[i] = 0; hc[i] = 0; hb[i] = 0; end
         m_valid = 1;
      end else begin
         // A pin level reaches the FSM two samples late; a pulse is a 0->1 step.
         sp = hs[1] & ~hs[2];
         cp = hc[1] & ~hc[2];
         bp = hb[1] & ~hb[2];
         effp = (int'(preset) > 999) ? 999 : int'(preset);
         low = 3;
         for (int i = 3; i >= 0; i--) if (bp[i]) low = i;
         case (m_mode)
            M_IDLE: begin
               m_data = effp;
               if (!cp && bp != 0) begin
                  m_mode = M_FOUL; m_err = 1; m_win = low; m_wv = 1;
               end else if (!cp && sp) begin
                  m_mode = M_RUN; run_cyc = 0;
               end
            end
            M_RUN: begin
               if (cp) begin
                  m_mode = M_IDLE; m_data = effp;
               end else if (bp != 0) begin
                  m_mode = M_LOCK; m_win = low; m_wv = 1;
               end else if (m_data == 0) begin
                  m_mode = M_TIMEOUT; m_to = 1;
               end else begin
                  if (run_cyc % TD == TD - 1) begin
                     m_data = m_data - 1;
                     if (m_data == 0) begin m_mode = M_TIMEOUT; m_to = 1; end
                  end
                  run_cyc++;
               end
            end
            default: begin
               if (cp) begin
                  m_mode = M_IDLE; m_data = effp; m_err = 0; m_win = 0; m_wv = 0; m_to = 0;
               end
            end
         endcase
         hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = start_btn;
         hc[2] = hc[1]; hc[1] = hc[0]; hc[0] = clear_btn;
         hb[2] = hb[1]; hb[1] = hb[0]; hb[0] = buzz;
      end
   end

   always @(negedge clk_50M) begin
      if (m_valid) begin
         check("model_DataOut", DataOut, m_data);
         check("model_ErrorFlag", ErrorFlag, m_err);
         check("model_winner", winner, m_win);
         check("model_winner_valid", winner_valid, m_wv);
         check("model_timeout", timeout, m_to);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_50M);
   endtask

   task automatic pulse_clear();
      clear_btn = 1'b1; cyc(4);
      clear_btn = 1'b0; cyc(3);
   endtask

   initial begin
      cyc(3);
      check("reset_DataOut", DataOut, 0);
      check("reset_ErrorFlag", ErrorFlag, 0);
      check("reset_winner_valid", winner_valid, 0);
      check("reset_timeout", timeout, 0);
      preset = 10'd25;
      rst_n = 1'b1;
      cyc(10);
      check("idle_DataOut_25", DataOut, 25);
      check("idle_timeout", timeout, 0);

      preset = 10'd1000; cyc(1);
      check("clamp_999", DataOut, 999);
      start_btn = 1'b1; cyc(6);
      check("before_first_dec", DataOut, 999);
      cyc(1);
      check("first_dec_998", DataOut, 998);
      start_btn = 1'b0;
      pulse_clear();
      check("clear_to_999", DataOut, 999);

      preset = 10'd3; cyc(2);
      start_btn = 1'b1; cyc(7);
      check("count_2", DataOut, 2);
      cyc(4);
      check("count_1", DataOut, 1);
      cyc(3);
      check("pre_timeout", timeout, 0);
      cyc(1);
      check("count_0", DataOut, 0);
      check("timeout_set", timeout, 1);
      start_btn = 1'b0; cyc(8);
      check("timeout_hold", timeout, 1);
      pulse_clear();
      check("after_clear_3", DataOut, 3);
      check("after_clear_to", timeout, 0);

      buzz = 4'b0100; cyc(2);
      check("foul_not_yet", ErrorFlag, 0);
      cyc(1);
      check("foul_flag", ErrorFlag, 1);
      check("foul_winner", winner, 2);
      check("foul_valid", winner_valid, 1);
      buzz = 4'b0000; start_btn = 1'b1; cyc(6);
      check("foul_start_ignored", ErrorFlag, 1);
      check("foul_DataOut", DataOut, 3);
      start_btn = 1'b0;
      pulse_clear();
      check("foul_cleared", ErrorFlag, 0);
      check("foul_valid_cleared", winner_valid, 0);

      preset = 10'd7; cyc(2);
      start_btn = 1'b1; cyc(4);
      buzz = 4'b1010; cyc(4);
      check("lock_frozen_7", DataOut, 7);
      check("lock_winner_1", winner, 1);
      check("lock_valid", winner_valid, 1);
      start_btn = 1'b0; buzz = 4'b1011; cyc(5);
      check("lock_second_ignored", winner, 1);
      check("lock_still_7", DataOut, 7);
      buzz = 4'b0000;
      pulse_clear();

      preset = 10'd0; cyc(2);
      start_btn = 1'b1; cyc(3);
      check("zero_run_to0", timeout, 0);
      cyc(1);
      check("zero_timeout", timeout, 1);
      check("zero_DataOut", DataOut, 0);
      start_btn = 1'b0;
      pulse_clear();

      preset = 10'd5; cyc(2);
      start_btn = 1'b1; buzz = 4'b0000; cyc(6);
      check("mid_run_5", DataOut, 5);
      rst_n = 1'b0; cyc(1);
      check("rst_DataOut", DataOut, 0);
      check("rst_timeout", timeout, 0);
      start_btn = 1'b0; rst_n = 1'b1; cyc(3);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(19) == 0) start_btn = ~start_btn;
         if ($urandom_range(39) == 0) clear_btn = ~clear_btn;
         for (int b = 0; b < 4; b++)
            if ($urandom_range(59) == 0) buzz[b] = ~buzz[b];
         if ($urandom_range(99) == 0)
            preset = ($urandom_range(3) == 0) ? 10'($urandom_range(1023, 990)) : 10'($urandom_range(12));
         rst_n = ($urandom_range(499) != 0);
         cyc(1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
